xilly_seekable_mem: RTL and testbench

Parametrised seekable memory endpoint for a Xillybus address/data device pair (`/dev/xillybus_mem_*`), DW bits wide and 2^AW entries deep, in the `bus_clk` domain next to the loopback FIFOs. It replaces the single-cycle inferred RAM with independent auto-incrementing read and write pointers, both loaded on seek. A read-ahead stage sustains one word per clock, and same-cycle write-to-read forwarding keeps reads coherent. End-of-memory on the read stream is signalled with EOF.

---
 rtl/xilly_seekable_mem.sv | 103 ++++++++++
 tb/tb_xilly_seekable_mem.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/xilly_seekable_mem.sv
// rtl/xilly_seekable_mem.sv - seekable auto-incrementing memory endpoint for a Xillybus address/data device pair
// Optional macro XILLY_SEEKABLE_MEM_EOF_EN: stop after the last word with EOF instead of wrapping.
module xilly_seekable_mem #(
   parameter int DW = 8,
   parameter int AW = 5
) (
   input  logic          bus_clk,
   input  logic          bus_rst_n,
   input  logic          user_r_mem_rden,
   output logic          user_r_mem_empty,
   output logic [DW-1:0] user_r_mem_data,
   output logic          user_r_mem_eof,
   input  logic          user_r_mem_open,
   input  logic          user_w_mem_wren,
   output logic          user_w_mem_full,
   input  logic [DW-1:0] user_w_mem_data,
   input  logic          user_w_mem_open,
   input  logic [AW-1:0] user_mem_addr,
   input  logic          user_mem_addr_update
);
   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {
      S_CLOSED = 2'd0,
      S_PRIME  = 2'd1,
      S_STREAM = 2'd2
`ifdef XILLY_SEEKABLE_MEM_EOF_EN
      , S_END  = 2'd3
`endif
   } state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] q;
   logic [AW-1:0] rptr, wptr, raddr;
   logic          r_open_q, w_open_q;
   logic          r_rise, w_rise, we, rd_take, last_word;

   assign r_rise    = user_r_mem_open & ~r_open_q;
   assign w_rise    = user_w_mem_open & ~w_open_q;
   assign we        = user_w_mem_wren & user_w_mem_open;
   assign rd_take   = (state == S_STREAM) & user_r_mem_open & user_r_mem_rden;
   assign last_word = (rptr == AW'(DEPTH - 1));
   // Read one word ahead on a take so q already holds the next head word.
   assign raddr     = rptr + {{(AW-1){1'b0}}, rd_take};

   assign user_w_mem_full  = 1'b0;
   assign user_r_mem_empty = ~((state == S_STREAM) & user_r_mem_open);
`ifdef XILLY_SEEKABLE_MEM_EOF_EN
   assign user_r_mem_eof   = (state == S_END) & user_r_mem_open;
`else
   assign user_r_mem_eof   = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      if (!user_r_mem_open) begin
         state_nxt = S_CLOSED;
      end else begin
         case (state)
            S_CLOSED: if (r_rise) state_nxt = S_PRIME;
            S_PRIME:  if (!user_mem_addr_update) state_nxt = S_STREAM;
            S_STREAM: begin
               if (user_mem_addr_update) state_nxt = S_PRIME;
`ifdef XILLY_SEEKABLE_MEM_EOF_EN
               else if (user_r_mem_rden && last_word) state_nxt = S_END;
`endif
            end
`ifdef XILLY_SEEKABLE_MEM_EOF_EN
            S_END:    if (user_mem_addr_update) state_nxt = S_PRIME;
`endif
            default:  state_nxt = S_CLOSED;
         endcase
      end
   end

   // Open-edge detectors reset high so a stream already open at reset release stays closed.
   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         state           <= S_CLOSED;
         rptr            <= '0;
         wptr            <= '0;
         r_open_q        <= 1'b1;
         w_open_q        <= 1'b1;
         user_r_mem_data <= '0;
      end else begin
         state    <= state_nxt;
         r_open_q <= user_r_mem_open;
         w_open_q <= user_w_mem_open;
         if (r_rise || user_mem_addr_update) rptr <= user_mem_addr;
         else if (rd_take)                   rptr <= rptr + AW'(1);
         if (w_rise || user_mem_addr_update) wptr <= user_mem_addr;
         else if (we)                        wptr <= wptr + AW'(1);
         if (rd_take) user_r_mem_data <= q;
      end
   end

   always_ff @(posedge bus_clk) begin
      if (we) mem[wptr] <= user_w_mem_data;
      if (we && (wptr == raddr)) q <= user_w_mem_data;
      else                       q <= mem[raddr];
   end
endmodule

// File: tb/tb_xilly_seekable_mem.sv
// tb/tb_xilly_seekable_mem.sv - scoreboard bench for xilly_seekable_mem with a behavioural reference model
module tb_xilly_seekable_mem;
   localparam int DW = 8;
   localparam int AW = 5;
   localparam int DEPTH = 32;
`ifdef XILLY_SEEKABLE_MEM_EOF_EN
   localparam bit EOF_EN = 1'b1;
`else
   localparam bit EOF_EN = 1'b0;
`endif
   localparam int P_CLOSED = 0, P_PRIME = 1, P_STREAM = 2, P_END = 3;

   logic          bus_clk = 1'b0;
   logic          bus_rst_n;
   logic          user_r_mem_rden;
   logic          user_r_mem_empty;
   logic [DW-1:0] user_r_mem_data;
   logic          user_r_mem_eof;
   logic          user_r_mem_open;
   logic          user_w_mem_wren;
   logic          user_w_mem_full;
   logic [DW-1:0] user_w_mem_data;
   logic          user_w_mem_open;
   logic [AW-1:0] user_mem_addr;
   logic          user_mem_addr_update;

   xilly_seekable_mem #(.DW(DW), .AW(AW)) dut (
      .bus_clk              (bus_clk),
      .bus_rst_n            (bus_rst_n),
      .user_r_mem_rden      (user_r_mem_rden),
      .user_r_mem_empty     (user_r_mem_empty),
      .user_r_mem_data      (user_r_mem_data),
      .user_r_mem_eof       (user_r_mem_eof),
      .user_r_mem_open      (user_r_mem_open),
      .user_w_mem_wren      (user_w_mem_wren),
      .user_w_mem_full      (user_w_mem_full),
      .user_w_mem_data      (user_w_mem_data),
      .user_w_mem_open      (user_w_mem_open),
      .user_mem_addr        (user_mem_addr),
      .user_mem_addr_update (user_mem_addr_update)
   );

   always #5 bus_clk = ~bus_clk;

   logic [7:0] mem_m [DEPTH];
   logic [7:0] exp_q [$];
   logic [7:0] last_m;
   int         rptr_m, wptr_m, phase;
   bit         ropen_prev, wopen_prev, hs;
   int         vectors = 0;
   int         miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      phase = P_CLOSED; rptr_m = 0; wptr_m = 0; last_m = 8'h00;
      ropen_prev = 1'b1; wopen_prev = 1'b1;
   endtask

   // Monitor: a handshake seen before a rising edge yields a data word checked at the next falling edge.
   initial begin
      hs = 1'b0;
      forever begin
         @(negedge bus_clk);
         if (hs) begin
            if (exp_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL rdata: got %0h, expected no word at %0t", user_r_mem_data, $time);
            end else begin
               check("rdata", user_r_mem_data, exp_q.pop_front());
            end
         end
         #3;
         hs = user_r_mem_rden && !user_r_mem_empty && user_r_mem_open && bus_rst_n;
      end
   end

   // One clock of stimulus; called just after a falling edge, returns just after the next one.
   task automatic step(input bit rd, input bit wr, input logic [7:0] wd, input bit sk, input logic [4:0] sa);
      bit rd_ok;
      user_r_mem_rden = rd; user_w_mem_wren = wr; user_w_mem_data = wd;
      user_mem_addr_update = sk; user_mem_addr = sa;
      rd_ok = rd && user_r_mem_open && (phase == P_STREAM);
      if (rd_ok) begin
         exp_q.push_back(mem_m[rptr_m]);
         last_m = mem_m[rptr_m];
      end
      @(posedge bus_clk);
      if (wr && user_w_mem_open) begin
         mem_m[wptr_m] = wd;
         wptr_m = (wptr_m + 1) % DEPTH;
      end
      if ((user_w_mem_open && !wopen_prev) || sk) wptr_m = sa;
      wopen_prev = user_w_mem_open;
      if (!user_r_mem_open) phase = P_CLOSED;
      else if (phase == P_CLOSED) begin
         if (!ropen_prev) begin rptr_m = sa; phase = P_PRIME; end
      end else if (sk) begin
         rptr_m = sa; phase = P_PRIME;
      end else if (phase == P_PRIME) phase = P_STREAM;
      else if (rd_ok) begin
         if (rptr_m == DEPTH - 1 && EOF_EN) phase = P_END;
         rptr_m = (rptr_m + 1) % DEPTH;
      end
      ropen_prev = user_r_mem_open;
      @(negedge bus_clk);
      check("empty", user_r_mem_empty, phase != P_STREAM);
      check("eof", user_r_mem_eof, phase == P_END);
      check("full", user_w_mem_full, 0);
      #1;
   endtask

   task automatic seek(input logic [4:0] a);
      step(0, 0, 0, 1, a);
      step(0, 0, 0, 0, 0);
   endtask

   task automatic reads(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus_rst_n = 1'b0;
      user_r_mem_rden = 0; user_w_mem_wren = 0; user_w_mem_data = 0;
      user_r_mem_open = 0; user_w_mem_open = 0; user_mem_addr = 0; user_mem_addr_update = 0;
      model_reset();
      @(negedge bus_clk); @(negedge bus_clk);
      check("rst_data", user_r_mem_data, 0);
      check("rst_empty", user_r_mem_empty, 1);
      check("rst_eof", user_r_mem_eof, 0);
      check("rst_full", user_w_mem_full, 0);
      #1 bus_rst_n = 1'b1;
      step(0, 0, 0, 0, 0);
      user_r_mem_open = 1; user_w_mem_open = 1;
      step(0, 0, 0, 0, 0);

      // Sequential fill and readback with rden held high
      for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i), 0, 0);
      seek(0);
      reads(DEPTH);
      step(0, 0, 0, 0, 0);

      // Back-to-back seeks restart the prime cycle
      step(0, 0, 0, 1, 5'h10);
      step(0, 0, 0, 1, 5'h10);
      step(0, 0, 0, 0, 0);
      reads(3);

      // Forwarding to the head word and to the read-ahead word
      seek(5);
      step(0, 1, 8'h5A, 0, 0);
      step(1, 1, 8'hA5, 0, 0);
      reads(3);

      // Read wrap or EOF at the end of memory
      seek(30);
      reads(4);
      step(0, 0, 0, 0, 0);

      // Write pointer wrap
      seek(31);
      step(0, 1, 8'h11, 0, 0);
      step(0, 1, 8'h22, 0, 0);
      seek(31);
      reads(2);
      seek(0);
      reads(1);

      // Close mid-burst: empty rises at once, data holds
      seek(0);
      reads(3);
      user_r_mem_open = 0; user_r_mem_rden = 1;
      #1;
      check("close_empty", user_r_mem_empty, 1);
      check("close_data", user_r_mem_data, last_m);
      reads(2);
      user_r_mem_open = 1;
      step(0, 0, 0, 0, 5'd8);
      step(0, 0, 0, 0, 0);
      reads(2);

      // Reset mid-burst: stays closed until r_open rises again
      reads(2);
      bus_rst_n = 1'b0;
      #1;
      check("mid_rst_data", user_r_mem_data, 0);
      check("mid_rst_empty", user_r_mem_empty, 1);
      check("mid_rst_eof", user_r_mem_eof, 0);
      model_reset();
      @(negedge bus_clk);
      #1 bus_rst_n = 1'b1;
      reads(3);
      user_r_mem_open = 0;
      step(0, 0, 0, 0, 0);
      user_r_mem_open = 1;
      step(0, 0, 0, 0, 5'd3);
      step(0, 0, 0, 0, 0);
      reads(2);

      // Randomised concurrent reads, writes and seeks
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 8'($urandom),
              $urandom_range(0, 15) == 0, 5'($urandom));

      step(0, 0, 0, 0, 0);
      @(negedge bus_clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d words outstanding, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
